// File: rtl/sseg_cap_pkg.sv
// Shared constants, FSM state type and the active-low hex segment table for the
// seven-segment capture block.
package sseg_cap_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } cap_state_e;

  // Bit 0 of each entry is segment a, bit 6 is segment g; a 0 lights the segment.
  localparam logic [0:SEG_W-1] HEX_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Returns {select_ok, digit_index}; anything but a single low anode is "no digit".
  function automatic logic [2:0] an_decode(input logic [NUM_DIGITS-1:0] an);
    logic [2:0] r;
    case (an)
      4'b1110: r = {1'b1, 2'd0};
      4'b1101: r = {1'b1, 2'd1};
      4'b1011: r = {1'b1, 2'd2};
      4'b0111: r = {1'b1, 2'd3};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// Combinational segment-pattern to hex-nibble decoder; code_ok is low for any
// pattern that is not in the hex table, in which case the nibble reads 0.
module sseg_to_hex
  import sseg_cap_pkg::*;
(
  input  logic [0:SEG_W-1] seg_i,
  output logic             code_ok_o,
  output logic [3:0]       nibble_o
);

  always_comb begin
    code_ok_o = 1'b0;
    nibble_o  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == HEX_TAB[i]) begin
        code_ok_o = 1'b1;
        nibble_o  = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sseg_4capture.sv
// Captures a multiplexed 4-digit seven-segment display and rebuilds its 16-bit value.
// Optional SSEG_CAP_CONFIRM_EN: publish only when two consecutive clean scans agree.
module sseg_4capture
  import sseg_cap_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:SEG_W-1]      SSeg,
  input  logic [NUM_DIGITS-1:0] an,
  output logic [15:0]           num,
  output logic                  num_valid,
  output logic                  seg_err,
  output logic [7:0]            scan_cnt
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [NUM_DIGITS-1:0] an_sync_q  [SYNC_STAGES];
  logic [0:SEG_W-1]      seg_sync_q [SYNC_STAGES];
  logic [NUM_DIGITS-1:0] an_prev_q;
  logic [0:SEG_W-1]      seg_prev_q;
  logic [NUM_DIGITS-1:0] an_s;
  logic [0:SEG_W-1]      seg_s;
  logic                  changed;
  logic [2:0]            sel;
  logic                  sel_ok;
  logic [1:0]            sel_idx;

  cap_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  capture;

  logic [3:0]            digit_q [NUM_DIGITS];
  logic [3:0]            digit_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seen_q, seen_d, seen_cap;
  logic [NUM_DIGITS-1:0] bad_q, bad_d, bad_cap;
  logic                  complete;
  logic                  publish;
  logic [15:0]           assembled;
  logic                  code_ok;
  logic [3:0]            nibble;

  logic [15:0]           num_q;
  logic                  num_valid_q;
  logic                  seg_err_q;
  logic [7:0]            scan_cnt_q;

  // Synchronisers idle at all-ones: blank display, no anode selected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        an_sync_q[i]  <= '1;
        seg_sync_q[i] <= '1;
      end
      an_prev_q  <= '1;
      seg_prev_q <= '1;
    end else begin
      an_sync_q[0]  <= an;
      seg_sync_q[0] <= SSeg;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        an_sync_q[i]  <= an_sync_q[i-1];
        seg_sync_q[i] <= seg_sync_q[i-1];
      end
      an_prev_q  <= an_s;
      seg_prev_q <= seg_s;
    end
  end

  assign an_s    = an_sync_q[SYNC_STAGES-1];
  assign seg_s   = seg_sync_q[SYNC_STAGES-1];
  assign changed = (an_s != an_prev_q) || (seg_s != seg_prev_q);
  assign sel     = an_decode(an_s);
  assign sel_ok  = sel[2];
  assign sel_idx = sel[1:0];

  sseg_to_hex u_dec (
    .seg_i     (seg_s),
    .code_ok_o (code_ok),
    .nibble_o  (nibble)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sel_ok) state_d = SETTLE;
      end
      SETTLE: begin
        if (!sel_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          capture = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!sel_ok)      state_d = IDLE;
        else if (changed) state_d = SETTLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // seen/bad as they stand including this cycle's capture; a full set closes the scan.
  always_comb begin
    digit_d  = digit_q;
    seen_cap = seen_q;
    bad_cap  = bad_q;
    if (capture) begin
      digit_d[sel_idx]  = nibble;
      seen_cap[sel_idx] = 1'b1;
      bad_cap[sel_idx]  = ~code_ok;
    end
    complete  = capture && (&seen_cap);
    assembled = {digit_d[3], digit_d[2], digit_d[1], digit_d[0]};
    seen_d    = complete ? '0 : seen_cap;
    bad_d     = complete ? '0 : bad_cap;
  end

`ifdef SSEG_CAP_CONFIRM_EN
  logic [15:0] cand_q;
  logic        cand_vld_q;

  assign publish = complete && !(|bad_cap) && cand_vld_q && (cand_q == assembled);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
    end else if (complete) begin
      cand_q     <= assembled;
      cand_vld_q <= !(|bad_cap);
    end
  end
`else
  assign publish = complete;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      seen_q      <= '0;
      bad_q       <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
      seg_err_q   <= 1'b0;
      scan_cnt_q  <= '0;
    end else begin
      digit_q     <= digit_d;
      seen_q      <= seen_d;
      bad_q       <= bad_d;
      num_valid_q <= publish;
      seg_err_q   <= complete && (|bad_cap);
      if (publish) begin
        num_q      <= assembled;
        scan_cnt_q <= scan_cnt_q + 8'd1;
      end
    end
  end

  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign seg_err   = seg_err_q;
  assign scan_cnt  = scan_cnt_q;

endmodule
